// File: rtl/logic_unit_seq.sv
// logic_unit_seq: bitwise logic on WIDTH-bit operands, SLICE bits per cycle; LOGIC_UNIT_EXT_OPS_EN adds ops 1xx.
// Latency N+1 cycles start->done; no backpressure: start ignored while busy, accepted again in IDLE/DONE.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             op_err
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic             w_accept;
  logic             w_last;
  logic             w_illegal;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_result_nxt;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_comb begin
    w_a_sl = r_a[r_cnt*SLICE +: SLICE];
    w_b_sl = r_b[r_cnt*SLICE +: SLICE];
    case (r_op)
      3'b000:  w_slice = w_a_sl & w_b_sl;
      3'b001:  w_slice = w_a_sl | w_b_sl;
      3'b010:  w_slice = w_a_sl ^ w_b_sl;
      3'b011:  w_slice = ~(w_a_sl | w_b_sl);
`ifdef LOGIC_UNIT_EXT_OPS_EN
      3'b100:  w_slice = ~(w_a_sl & w_b_sl);
      3'b101:  w_slice = ~(w_a_sl ^ w_b_sl);
      3'b110:  w_slice = w_a_sl & ~w_b_sl;
      default: w_slice = w_a_sl;
`else
      default: w_slice = '0;
`endif
    endcase
  end

`ifdef LOGIC_UNIT_EXT_OPS_EN
  assign w_illegal = 1'b0;
`else
  assign w_illegal = r_op[2];
`endif

  // Merge the current slice into the running result so zero sees the final word.
  always_comb begin
    w_result_nxt = r_result;
    w_result_nxt[r_cnt*SLICE +: SLICE] = w_slice;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= A;
      r_b      <= B;
      r_op     <= op;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_result <= w_result_nxt;
      if (w_last) begin
        r_cnt  <= '0;
        r_zero <= (w_result_nxt == '0);
        r_err  <= w_illegal;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign op_err = r_err;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: a 32/8 instance and a 16/16 (single RUN cycle) instance.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [2:0]  op1, op2;
  logic [31:0] a1, b1, res1;
  logic [15:0] a2, b2, res2;
  logic        busy1, done1, zero1, err1;
  logic        busy2, done2, zero2, err2;

  int total = 0;
  int bad   = 0;

  logic [33:0] q1[$];
  logic [17:0] q2[$];
  logic [33:0] e1;
  logic [17:0] e2;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .result(res1), .zero(zero1), .op_err(err1)
  );

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .result(res2), .zero(zero2), .op_err(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no pulse");
      end else begin
        e1 = q1.pop_front();
        chk("dut1_result", 64'(res1), 64'(e1[33:2]));
        chk("dut1_zero", 64'(zero1), 64'(e1[1]));
        chk("dut1_op_err", 64'(err1), 64'(e1[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2_unexpected_done: got done=1 expected no pulse");
      end else begin
        e2 = q2.pop_front();
        chk("dut2_result", 64'(res2), 64'(e2[17:2]));
        chk("dut2_zero", 64'(zero2), 64'(e2[1]));
        chk("dut2_op_err", 64'(err2), 64'(e2[0]));
      end
    end
  end

  task automatic issue1(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start1 = 1'b1; op1 = o; a1 = a; b1 = b;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue2(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start2 = 1'b1; op2 = o; a2 = a; b2 = b;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Called at the first negedge after the start edge; counts busy cycles up to done.
  task automatic wait_done1(input string name, input int exp_cyc);
    int nb = 0;
    int cyc = 0;
    while (done1 !== 1'b1 && cyc < 50) begin
      if (busy1 === 1'b1) nb++;
      cyc++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 64'(done1), 64'd1);
    chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_cyc));
    chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic wait_done2(input string name, input int exp_cyc);
    int nb = 0;
    int cyc = 0;
    while (done2 !== 1'b1 && cyc < 50) begin
      if (busy2 === 1'b1) nb++;
      cyc++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 64'(done2), 64'd1);
    chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_cyc));
    chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start1 = 1'b0; op1 = 3'b000; a1 = '0; b1 = '0;
    start2 = 1'b0; op2 = 3'b000; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_result", 64'(res1), 64'd0);
    chk("rst_zero", 64'(zero1), 64'd0);
    chk("rst_op_err", 64'(err1), 64'd0);
    chk("rst_dut2_result", 64'(res2), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // AND
    q1.push_back({32'hF000_0034, 1'b0, 1'b0});
    issue1(3'b000, 32'hF0F0_1234, 32'hFF00_00FF);
    wait_done1("and", 4);

    // XOR to zero, then hold for 10 idle cycles
    q1.push_back({32'h0000_0000, 1'b1, 1'b0});
    issue1(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_done1("xor", 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("xor_hold_result", 64'(res1), 64'd0);
      chk("xor_hold_zero", 64'(zero1), 64'd1);
    end

    // NOR with input churn and start pulses during RUN
    q1.push_back({32'hFFFF_0000, 1'b0, 1'b0});
    issue1(3'b011, 32'h0000_0000, 32'h0000_FFFF);
    start1 = 1'b1; op1 = 3'b000; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    start1 = 1'b0;
    wait_done1("nor", 2);
    @(negedge clk);
    chk("nor_no_extra_op", 64'(busy1), 64'd0);
    repeat (6) @(negedge clk);
    chk("nor_result_held", 64'(res1), 64'hFFFF_0000);

    // Back-to-back: start held through DONE
    q1.push_back({32'h8000_0001, 1'b0, 1'b0});
    q1.push_back({32'h8000_0001, 1'b0, 1'b0});
    @(negedge clk);
    start1 = 1'b1; op1 = 3'b001; a1 = 32'h0000_0001; b1 = 32'h8000_0000;
    @(negedge clk);
    wait_done1("b2b_first", 4);
    @(negedge clk);
    chk("b2b_no_gap_busy", 64'(busy1), 64'd1);
    chk("b2b_no_gap_done", 64'(done1), 64'd0);
    start1 = 1'b0;
    wait_done1("b2b_second", 4);

    // Reset in the second RUN cycle aborts without a done pulse
    issue1(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    chk("abort_result", 64'(res1), 64'd0);
    chk("abort_zero", 64'(zero1), 64'd0);
    chk("abort_op_err", 64'(err1), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort_still_idle", 64'(busy1), 64'd0);
    q1.push_back({32'h00FF_FF00, 1'b0, 1'b0});
    issue1(3'b001, 32'h00FF_0000, 32'h0000_FF00);
    wait_done1("after_abort", 4);

    // Upper op codes
`ifdef LOGIC_UNIT_EXT_OPS_EN
    q1.push_back({32'hF00F_F00F, 1'b0, 1'b0});
    q1.push_back({32'h0F0F_0F0F, 1'b0, 1'b0});
    q1.push_back({32'h0F00_0F00, 1'b0, 1'b0});
`else
    q1.push_back({32'h0000_0000, 1'b1, 1'b1});
    q1.push_back({32'h0000_0000, 1'b1, 1'b1});
    q1.push_back({32'h0000_0000, 1'b1, 1'b1});
`endif
    issue1(3'b101, 32'h0F0F_0F0F, 32'h00FF_00FF);
    wait_done1("op101", 4);
    issue1(3'b111, 32'h0F0F_0F0F, 32'h00FF_00FF);
    wait_done1("op111", 4);
    issue1(3'b110, 32'h0F0F_0F0F, 32'h00FF_00FF);
    wait_done1("op110", 4);

    // Legal op after an illegal/extended one clears op_err
    q1.push_back({32'h0F0F_0F0F, 1'b0, 1'b0});
    issue1(3'b001, 32'h0F0F_0F0F, 32'h0000_0000);
    wait_done1("or_after_ext", 4);

    // Single-slice instance: done two cycles after start
    q2.push_back({16'h0000, 1'b1, 1'b0});
    issue2(3'b010, 16'hBEEF, 16'hBEEF);
    wait_done2("n1_xor", 1);
    q2.push_back({16'h00F0, 1'b0, 1'b0});
    issue2(3'b000, 16'hF0F0, 16'h0FF0);
    wait_done2("n1_and", 1);

    repeat (5) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
